// File: rtl/booth_pkg.sv
// Shared types and control encodings for the radix-4 Booth multiplier sequencer.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd2;
    localparam logic [2:0] ALU_CLR  = 3'd3;

    localparam logic MUX_M    = 1'b0;
    localparam logic MUX_ZERO = 1'b1;

    localparam logic SHIFT_LEFT = 1'b0;

endpackage

// File: rtl/booth_ctrl_if.sv
// Handshake and datapath-control bundle between the Booth sequencer and its requester/datapath.
interface booth_ctrl_if;
    logic       start;
    logic       abort;
    logic [2:0] cmp0;
    logic [2:0] cmp1;
    logic       busy;
    logic       done;
    logic       load;
    logic       muxsel;
    logic [2:0] ALUop;
    logic       shift_direction;
    logic [2:0] Tshift_amount;
    logic [2:0] shift_amount;
    logic       out_enable;

    // Requester + datapath side.
    modport master (
        output start, abort, cmp0, cmp1,
        input  busy, done, load, muxsel, ALUop, shift_direction,
               Tshift_amount, shift_amount, out_enable
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cmp0, cmp1,
        output busy, done, load, muxsel, ALUop, shift_direction,
               Tshift_amount, shift_amount, out_enable
    );
endinterface

// File: rtl/booth_digit_dec.sv
// Maps one 3-bit Booth group and its step index to the datapath controls for that step.
module booth_digit_dec
    import booth_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [2:0]       g,
    input  logic [CNT_W-1:0] k,
    output logic             load,
    output logic             muxsel,
    output logic [2:0]       alu_op,
    output logic [2:0]       tshift
);

    logic [2:0] base;

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        load   = 1'b0;
        muxsel = MUX_ZERO;
        alu_op = ALU_PASS;
        tshift = 3'd0;
        base   = 3'(k) << 1;  // group k carries weight 4^k, i.e. a left shift of 2k
        unique case (g)
            3'b001, 3'b010: begin
                load = 1'b1; muxsel = MUX_M; alu_op = ALU_ADD; tshift = base;
            end
            3'b011: begin
                load = 1'b1; muxsel = MUX_M; alu_op = ALU_ADD; tshift = base | 3'd1;
            end
            3'b100: begin
                load = 1'b1; muxsel = MUX_M; alu_op = ALU_SUB; tshift = base | 3'd1;
            end
            3'b101, 3'b110: begin
                load = 1'b1; muxsel = MUX_M; alu_op = ALU_SUB; tshift = base;
            end
            default: ;  // 000 / 111: digit 0, P holds
        endcase
    end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencer for an 8x4 radix-4 Booth multiplier: clear P, N_STEPS add/sub steps, one done cycle.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int N_STEPS = 2
) (
    input  logic         clk,
    input  logic         rst,
    booth_ctrl_if.slave  bus
);

    localparam int               CNT_W = $clog2(N_STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_STEPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] grp;
    logic       dec_load, dec_muxsel;
    logic [2:0] dec_alu_op, dec_tshift;

    assign grp = (cnt_q == '0) ? bus.cmp0 : bus.cmp1;

    booth_digit_dec #(.CNT_W(CNT_W)) u_dec (
        .g      (grp),
        .k      (cnt_q),
        .load   (dec_load),
        .muxsel (dec_muxsel),
        .alu_op (dec_alu_op),
        .tshift (dec_tshift)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:  if (bus.start && !bus.abort) state_d = CLEAR;
            CLEAR: begin
                cnt_d   = '0;
                state_d = bus.abort ? IDLE : STEP;
            end
            STEP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.abort)          state_d = IDLE;
                else if (cnt_q == LAST) state_d = DONE;
            end
            DONE:  state_d = bus.start ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only STEP looks at the comparators; every other state is a pure state decode.
    always_comb begin
        bus.busy            = 1'b0;
        bus.done            = 1'b0;
        bus.load            = 1'b0;
        bus.muxsel          = MUX_ZERO;
        bus.ALUop           = ALU_PASS;
        bus.shift_direction = SHIFT_LEFT;
        bus.Tshift_amount   = 3'd0;
        bus.shift_amount    = 3'd0;
        bus.out_enable      = 1'b0;
        unique case (state_q)
            CLEAR: begin
                bus.busy  = 1'b1;
                bus.load  = 1'b1;
                bus.ALUop = ALU_CLR;
            end
            STEP: begin
                bus.busy          = 1'b1;
                bus.load          = dec_load;
                bus.muxsel        = dec_muxsel;
                bus.ALUop         = dec_alu_op;
                bus.Tshift_amount = dec_tshift;
            end
            DONE: begin
                bus.done       = 1'b1;
                bus.out_enable = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench: Booth-digit reference for each step plus a behavioural P register checked against M*Q.
module tb_booth_ctrl;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_ctrl_if bif ();

    booth_ctrl #(.N_STEPS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] p_model;
    logic [7:0] m_cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_fixed(input string tag, input logic busy, input logic done,
                               input logic oe);
        check({tag, ".busy"}, bif.busy, busy);
        check({tag, ".done"}, bif.done, done);
        check({tag, ".oe"}, bif.out_enable, oe);
        check({tag, ".sdir"}, bif.shift_direction, 0);
        check({tag, ".samt"}, bif.shift_amount, 0);
    endtask

    task automatic check_idle(input string tag);
        check_fixed(tag, 1'b0, 1'b0, 1'b0);
        check({tag, ".load"}, bif.load, 0);
        check({tag, ".mux"}, bif.muxsel, 1);
        check({tag, ".alu"}, bif.ALUop, 2);
        check({tag, ".tsh"}, bif.Tshift_amount, 0);
    endtask

    // Behavioural P register driven by whatever the controller asserts this cycle.
    task automatic dp_update();
        logic [7:0] a;
        a = bif.muxsel ? 8'h00 : (m_cur << bif.Tshift_amount);
        if (bif.load) begin
            case (bif.ALUop)
                3'd0:    p_model = p_model + a;
                3'd1:    p_model = p_model - a;
                3'd2:    p_model = p_model;
                3'd3:    p_model = 8'h00;
                default: p_model = 8'hxx;
            endcase
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle(tag);
    endtask

    // Entry: DUT is in IDLE or DONE, before the next rising edge. Returns at the DONE-cycle negedge.
    task automatic do_op(input int m, input logic [3:0] q, input bit hold);
        int         qs, d, prod;
        logic [2:0] c0, c1, g;
        qs    = q[3] ? int'(q) - 16 : int'(q);
        prod  = (m * qs) & 255;
        c0    = {q[1], q[0], 1'b0};
        c1    = {q[3], q[2], q[1]};
        m_cur = 8'(m);
        p_model = 8'(m * 37 + 11);  // arbitrary stale P; CLEAR must wipe it
        bif.cmp0  = c0;
        bif.cmp1  = c1;
        bif.start = 1'b1;
        bif.abort = 1'b0;
        @(posedge clk); #1;
        if (!hold) bif.start = 1'b0;
        @(negedge clk);
        check_fixed("clear", 1'b1, 1'b0, 1'b0);
        check("clear.load", bif.load, 1);
        check("clear.mux", bif.muxsel, 1);
        check("clear.alu", bif.ALUop, 3);
        dp_update();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            g = (k == 0) ? c0 : c1;
            d = int'(g[1]) + int'(g[0]) - 2 * int'(g[2]);
            check_fixed($sformatf("step%0d", k), 1'b1, 1'b0, 1'b0);
            check($sformatf("step%0d.load", k), bif.load, (d != 0) ? 1 : 0);
            if (d != 0) begin
                check($sformatf("step%0d.mux", k), bif.muxsel, 0);
                check($sformatf("step%0d.alu", k), bif.ALUop, (d > 0) ? 0 : 1);
                check($sformatf("step%0d.tsh", k), bif.Tshift_amount,
                      2 * k + ((d == 2 || d == -2) ? 1 : 0));
            end
            dp_update();
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_fixed("done", 1'b0, 1'b1, 1'b1);
        check("done.load", bif.load, 0);
        check("done.mux", bif.muxsel, 1);
        check("done.alu", bif.ALUop, 2);
        check($sformatf("product(%0d*%0d)", m, qs), p_model, prod);
    endtask

    initial begin
        bit hold;
        rst       = 1'b1;
        bif.start = 1'b0;
        bif.abort = 1'b0;
        bif.cmp0  = 3'd0;
        bif.cmp1  = 3'd0;
        m_cur     = 8'd0;
        p_model   = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Directed cases: 5*3, 7*6, 7*-8
        do_op(5, 4'b0011, 1'b0);  idle_cycle("idle_a");
        do_op(7, 4'b0110, 1'b0);  idle_cycle("idle_b");
        do_op(7, 4'b1000, 1'b0);  idle_cycle("idle_c");

        // start held through a whole op chains straight into the next CLEAR
        do_op(-3, 4'b0101, 1'b1);
        do_op(15, 4'b1011, 1'b0);
        idle_cycle("idle_chain");

        // abort in STEP0
        bif.cmp0 = 3'b010; bif.cmp1 = 3'b011; bif.start = 1'b1;
        @(posedge clk); #1 bif.start = 1'b0;
        @(posedge clk); #1 bif.abort = 1'b1;
        @(negedge clk);
        check("abort_step.busy", bif.busy, 1);
        @(posedge clk); #1 bif.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_step");
        for (int i = 0; i < 3; i++) idle_cycle($sformatf("abort_step_after%0d", i));

        // abort in CLEAR
        bif.start = 1'b1;
        @(posedge clk); #1 bif.start = 1'b0; bif.abort = 1'b1;
        @(posedge clk); #1 bif.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_clear");

        // abort beats start in IDLE
        bif.start = 1'b1; bif.abort = 1'b1;
        @(posedge clk); #1 bif.start = 1'b0; bif.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_start_idle");

        // abort ignored in DONE: start still launches CLEAR
        do_op(-16, 4'b0111, 1'b0);
        bif.start = 1'b1; bif.abort = 1'b1;
        @(posedge clk); #1 bif.start = 1'b0;
        @(negedge clk);
        check("abort_done.busy", bif.busy, 1);
        check("abort_done.alu", bif.ALUop, 3);
        @(posedge clk); #1 bif.abort = 1'b0;
        @(negedge clk);
        check_idle("abort_done_then_clear");

        // synchronous reset during STEP1, then a full operation
        bif.start = 1'b1; bif.cmp0 = 3'b110; bif.cmp1 = 3'b001;
        @(posedge clk); #1 bif.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_step");
        do_op(5, 4'b0011, 1'b0);
        idle_cycle("after_reset_op");

        // Random operands with random back-to-back chaining
        hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hold = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            do_op(int'($urandom_range(0, 31)) - 16, 4'($urandom_range(0, 15)), hold);
            if (!hold) idle_cycle("rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
